instr_fetch_unit: RTL

//  Fetch stage upstream of reg32_2x2_pc: reads architectural PC (pcout), fetches instruction words

---
 rtl/cpu32_pkg.sv | 19 +
 rtl/fetch_queue.sv | 80 ++++++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu32_pkg.sv
// Shared types for the 32-bit CPU front end: word width, fetch FSM states
// and the instruction-queue entry layout.
package cpu32_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    INCR,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } q_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Supports push+pop in the same cycle (also when full); clear empties it at once.
module fetch_queue
  import cpu32_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int QAW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_pc,
  input  logic [WORD_W-1:0] push_instr,
  input  logic              pop,
  input  logic              clear,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head_pc,
  output logic [WORD_W-1:0] head_instr
);

  q_entry_t       mem_q [QDEPTH];
  logic [QAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QAW:0]   count_q, count_d;
  logic           push_ok;
  logic           pop_ok;

  assign full  = (count_q == (QAW+1)'(QDEPTH));
  assign empty = (count_q == '0);

  // NOTE: entry storage has no reset; nothing reads it without a matching
  // count, and the head is masked to zero while the queue is empty.
  assign head_pc    = empty ? '0 : mem_q[rd_ptr_q].pc;
  assign head_instr = empty ? '0 : mem_q[rd_ptr_q].instr;

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + QAW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + QAW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (QAW+1)'(1);
        2'b01:   count_d = count_q - (QAW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push_ok) begin
      mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one word fetch at a time from the architectural PC,
// queues {pc, instr} for decode, pulses pcincr per accepted word, handles redirects.
module instr_fetch_unit
  import cpu32_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int QAW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcin,
  output logic        pcincr,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              pend_incr_q, pend_incr_d;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_valid = ~q_empty;
  assign q_pop    = ir_valid & ir_ready & ~flush;
  // A redirect owns the PC this cycle, so it always beats the increment.
  assign pcincr   = pend_incr_q & ~flush;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    pend_incr_d = pend_incr_q;
    q_push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && !q_full) begin
          mem_addr_d = pcin;
          mem_req_d  = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack && !flush) begin
          q_push      = 1'b1;
          mem_req_d   = 1'b0;
          pend_incr_d = 1'b1;
          state_d     = INCR;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      INCR: begin
        pend_incr_d = 1'b0;
        state_d     = IDLE;
      end
      DRAIN: begin
        // The stale word still has to be retired on the bus before refetching.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      pend_incr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      pend_incr_q <= pend_incr_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH),
    .QAW   (QAW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_pc   (mem_addr_q),
    .push_instr(mem_rdata),
    .pop       (q_pop),
    .clear     (flush),
    .full      (q_full),
    .empty     (q_empty),
    .head_pc   (ir_pc),
    .head_instr(ir_data)
  );

endmodule
